// File: rtl/dct4_fwd_serial.sv
// Forward 4-point integer DCT (coefficients 64/83/36), serial valid/ready in and out.
// Optional macro DCT4_SHIFT_EN: round-half-up arithmetic right shift by SHIFT on each coefficient.
module dct4_fwd_serial #(
  parameter int SHIFT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] d_in,
  input  logic               d_in_valid,
  output logic               d_in_ready,
  output logic signed [23:0] d_out,
  output logic [1:0]         d_out_idx,
  output logic               d_out_valid,
  input  logic               d_out_ready
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    SEND = 2'd2
  } state_t;

`ifdef DCT4_SHIFT_EN
  localparam int ACC_W = 25;
`else
  localparam int ACC_W = 24;
`endif

  if (SHIFT < 1 || SHIFT > 8) begin : g_bad_shift
    $error("dct4_fwd_serial: SHIFT must be in 1..8");
  end

  state_t state, state_nxt;

  logic [1:0]         in_cnt;
  logic [1:0]         out_cnt;
  logic signed [15:0] x_q [4];
  logic signed [23:0] y_q [4];

  logic in_fire;
  logic out_fire;

  assign in_fire  = (state == LOAD) && d_in_valid;
  assign out_fire = (state == SEND) && d_out_ready;

  // ---------------------------------------------------------------------------
  // Butterfly datapath, evaluated continuously from the sample bank and
  // captured into the result bank only during CALC.
  // ---------------------------------------------------------------------------
  logic signed [16:0]      e0, e1, o0, o1;
  logic signed [ACC_W-1:0] e0_w, e1_w, o0_w, o1_w;
  logic signed [ACC_W-1:0] y_full [4];

  always_comb begin
    e0 = 17'(x_q[0]) + 17'(x_q[3]);
    e1 = 17'(x_q[1]) + 17'(x_q[2]);
    o0 = 17'(x_q[0]) - 17'(x_q[3]);
    o1 = 17'(x_q[1]) - 17'(x_q[2]);

    e0_w = ACC_W'(e0);
    e1_w = ACC_W'(e1);
    o0_w = ACC_W'(o0);
    o1_w = ACC_W'(o1);

    y_full[0] = (e0_w + e1_w) <<< 6;
    y_full[2] = (e0_w - e1_w) <<< 6;
    y_full[1] = o0_w * ACC_W'(83) + o1_w * ACC_W'(36);
    y_full[3] = o0_w * ACC_W'(36) - o1_w * ACC_W'(83);
  end

`ifdef DCT4_SHIFT_EN
  function automatic logic signed [23:0] scale(input logic signed [ACC_W-1:0] v);
    return 24'((v + (ACC_W'(1) <<< (SHIFT - 1))) >>> SHIFT);
  endfunction
`else
  function automatic logic signed [23:0] scale(input logic signed [ACC_W-1:0] v);
    return v;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  // FSM: next-state logic
  // NOTE: the default assignment up front keeps every path assigned, so no latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (in_fire && in_cnt == 2'd3)   state_nxt = CALC;
      CALC:                                     state_nxt = SEND;
      SEND:    if (out_fire && out_cnt == 2'd3) state_nxt = LOAD;
      default:                                  state_nxt = LOAD;
    endcase
  end

  // FSM: outputs; data and index are forced to zero outside SEND
  always_comb begin
    d_in_ready  = 1'b0;
    d_out_valid = 1'b0;
    d_out       = '0;
    d_out_idx   = '0;
    unique case (state)
      LOAD: d_in_ready = 1'b1;
      SEND: begin
        d_out_valid = 1'b1;
        d_out       = y_q[out_cnt];
        d_out_idx   = out_cnt;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters, sample bank and result bank
  // ---------------------------------------------------------------------------
  // NOTE: the small sample/result banks are reset explicitly so a partial
  // block can never leak into a later result after a mid-block reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt  <= '0;
      out_cnt <= '0;
      for (int i = 0; i < 4; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      if (in_fire) begin
        x_q[in_cnt] <= d_in;
        in_cnt      <= in_cnt + 2'd1;
      end
      if (state == CALC) begin
        for (int i = 0; i < 4; i++) y_q[i] <= scale(y_full[i]);
        out_cnt <= '0;
      end
      if (out_fire) out_cnt <= out_cnt + 2'd1;
    end
  end

endmodule

// File: tb/tb_dct4_fwd_serial.sv
// Directed self-checking bench for dct4_fwd_serial: impulse, basis, extremes,
// backpressure and mid-block reset, with hand-computed coefficients.
module tb_dct4_fwd_serial;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] d_in;
  logic               d_in_valid;
  logic               d_in_ready;
  logic signed [23:0] d_out;
  logic [1:0]         d_out_idx;
  logic               d_out_valid;
  logic               d_out_ready;

  int checks = 0;
  int errors = 0;

  dct4_fwd_serial #(.SHIFT(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .d_in        (d_in),
    .d_in_valid  (d_in_valid),
    .d_in_ready  (d_in_ready),
    .d_out       (d_out),
    .d_out_idx   (d_out_idx),
    .d_out_valid (d_out_valid),
    .d_out_ready (d_out_ready)
  );

  always #5 clk = ~clk;

  // Expected coefficient after the optional rounding shift (SHIFT=1)
  function automatic int scaled(input int v);
`ifdef DCT4_SHIFT_EN
    return (v + 1) >>> 1;
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic signed [15:0] v);
    int n = 0;
    bit done = 1'b0;
    d_in       = v;
    d_in_valid = 1'b1;
    while (!done && n < 20) begin
      done = d_in_ready;
      step();
      n++;
    end
    d_in_valid = 1'b0;
    check("in_accept", int'(done), 1);
  endtask

  task automatic get(input string tag, input int k, input int exp);
    int n = 0;
    d_out_ready = 1'b1;
    while (!d_out_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_valid"}, int'(d_out_valid), 1);
    check({tag, "_idx"},   int'(d_out_idx), k);
    check({tag, "_data"},  int'(d_out), scaled(exp));
    step();
  endtask

  task automatic blk(input string tag,
                     input logic signed [15:0] a, b, c, d,
                     input int y0, y1, y2, y3);
    put(a); put(b); put(c); put(d);
    get(tag, 0, y0);
    get(tag, 1, y1);
    get(tag, 2, y2);
    get(tag, 3, y3);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    d_in        = '0;
    d_in_valid  = 1'b0;
    d_out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_in_ready",  int'(d_in_ready), 1);
    check("rst_out_valid", int'(d_out_valid), 0);
    check("rst_out_data",  int'(d_out), 0);
    check("rst_out_idx",   int'(d_out_idx), 0);

    // Impulse with latency: CALC cycle after x3, then y0 valid
    put(16'sd1); put(16'sd0); put(16'sd0); put(16'sd0);
    check("lat_calc_valid", int'(d_out_valid), 0);
    check("lat_calc_ready", int'(d_in_ready), 0);
    step();
    check("lat_send_valid", int'(d_out_valid), 1);
    get("imp", 0, 64);
    get("imp", 1, 83);
    get("imp", 2, 64);
    get("imp", 3, 36);
    check("imp_back_to_load", int'(d_in_ready), 1);
    check("imp_idle_data", int'(d_out), 0);

    // DC and basis
    blk("dc",    16'sd1, 16'sd1, 16'sd1, 16'sd1, 256, 0, 0, 0);
    blk("basis", 16'sd0, 16'sd1, 16'sd0, 16'sd0, 64, 36, -64, -83);

    // Extremes
    blk("ext_a", 16'sd32767, 16'sd32767, -16'sd32768, -16'sd32768,
        -128, 7798665, 0, -3080145);
    blk("ext_b", 16'sd32767, -16'sd32768, -16'sd32768, 16'sd32767,
        -128, 0, 8388480, 0);

    // Backpressure at idx 1, with a stray d_in_valid during SEND
    put(16'sd1); put(16'sd0); put(16'sd0); put(16'sd0);
    get("bp", 0, 64);
    d_out_ready = 1'b0;
    d_in        = 16'sd5;
    d_in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", int'(d_out_valid), 1);
      check("bp_hold_idx",   int'(d_out_idx), 1);
      check("bp_hold_data",  int'(d_out), scaled(83));
      check("bp_hold_ready", int'(d_in_ready), 0);
      step();
    end
    d_in_valid = 1'b0;
    get("bp", 1, 83);
    get("bp", 2, 64);
    get("bp", 3, 36);
    // Stray sample must not have been absorbed into x0
    blk("post_bp", 16'sd0, 16'sd1, 16'sd0, 16'sd0, 64, 36, -64, -83);

    // Reset mid-block discards the partial block
    put(16'sd7);
    put(16'sd9);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_out_valid", int'(d_out_valid), 0);
    check("mid_rst_in_ready",  int'(d_in_ready), 1);
    blk("post_rst", 16'sd1, 16'sd0, 16'sd0, 16'sd0, 64, 83, 64, 36);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
